qword_memory_responder: RTL and testbench
=========================================

Name: qword_memory_responder

Overview:
- Responder end of the 128-bit qword refill/writeback bus driven by the data cache.
- Accepts one request at a time and performs a qword read or write on an on-chip backing store after a programmable latency.
- Returns a one-cycle completion pulse, with read data for reads.
- Sits between the cache bus port and main memory; acts as the simulation/FPGA main-memory model.

Parameters:
- BUS_ADDRESS_WIDTH, 20: byte-address width of the bus; request address is qword-granular, bits [BUS_ADDRESS_WIDTH-1:4].
- MEM_DEPTH_LOG2, 10: log2 of backing-store depth in qwords. Must be <= BUS_ADDRESS_WIDTH-4.
- LATENCY, 2: idle cycles inserted between sampling a request and performing the access. Range 0..15.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- bus_addr_i  in  BUS_ADDRESS_WIDTH-4  qword address of the request.
- bus_valid_i  in  1  request valid; initiator holds it high until it sees bus_valid_o.
- bus_we_i  in  1  1 = write (writeback), 0 = read (refill).
- bus_data_i  in  128  write data.
- bus_data_o  out  128  read data.
- bus_valid_o  out  1  completion pulse, exactly one cycle wide.
- bus_err_o  out  1  address out of range; valid only while bus_valid_o=1.

Behaviour:
- Reset is asynchronous and active-high on rst_i, single clock clk_i.
  - Reset values: bus_valid_o=0, bus_err_o=0, bus_data_o=0, state IDLE, latency counter 0.
  - Backing-store contents are not reset.
- States: IDLE, WAIT, ACCESS, ACK, RELEASE.
- IDLE:
  - If bus_valid_i=1 at a posedge, capture addr, we and data into request registers. This sample edge is S.
  - Next state is WAIT with counter=LATENCY, or ACCESS directly if LATENCY=0.
- WAIT: decrement counter each cycle; go to ACCESS when counter reaches 1.
- ACCESS (one cycle): drive the captured address into the RAM.
  - Write: commit captured data at the end of this cycle.
  - Read: RAM output is registered into bus_data_o at the end of this cycle.
  - Next state ACK.
- ACK: bus_valid_o=1 for exactly this cycle, first high in cycle S+LATENCY+2. Next state RELEASE.
- RELEASE: stay until bus_valid_i=0 is sampled, then go to IDLE. Minimum one cycle.
  - Prevents a held-high request from being serviced twice.
- Request inputs are ignored outside IDLE; only the captured copies are used.
- bus_data_o holds its value between ACKs and is unchanged by writes.
- Out of range: any captured address bit at or above MEM_DEPTH_LOG2 set.
  - No RAM read or write.
  - Timing is unchanged.
  - bus_err_o=1 during the ACK cycle; bus_data_o is forced to 0 for reads.
- Back-to-back requests: a new request sampled in IDLE the cycle after RELEASE exits is serviced normally.
  - Minimum request-to-request period is LATENCY+4 cycles.
- Reset mid-operation aborts the transaction immediately.
  - A write whose ACCESS cycle has not completed is not committed.
  - No ACK is issued after reset.
- bus_err_o is 0 whenever bus_valid_o=0.

Decomposition:
- Shared package, also reused by the cache:
  - BUS_DATA_WIDTH_SHIFT=4.
  - BUS_DATA_WIDTH=128.
  - Responder state encoding (3-bit): IDLE, WAIT, ACCESS, ACK, RELEASE.
- Sub-module qword_ram:
  - Single-port, depth 2^MEM_DEPTH_LOG2 x 128.
  - Synchronous write, synchronous registered read.
  - Inputs: clk_i, en_i, we_i, addr_i, data_i. Output: data_o.
  - No reset, so it infers block RAM.

Test Plan:
- Write then read, LATENCY=2:
  - Write 0x0123456789ABCDEF_FEDCBA9876543210 to qword address 0x0005, then read 0x0005.
  - Each bus_valid_o pulse is one cycle, 4 cycles after the sample edge.
  - Read returns the same value; bus_err_o=0 for both.
- LATENCY=0:
  - Read of a preloaded qword at 0x03FF.
  - bus_valid_o high in cycle S+2 with the preloaded data; wrap of the top in-range address is correct.
- Held request:
  - Keep bus_valid_i high for 10 cycles after a single read of 0x0010.
  - Exactly one ACK pulse; RELEASE holds until bus_valid_i drops; no second access.
- Out of range (MEM_DEPTH_LOG2=10):
  - Write to 0x0400, then read 0x0000.
  - Write ACKs with bus_err_o=1 and leaves qword 0 unchanged.
  - Read of 0x0400 returns bus_data_o=0 with bus_err_o=1.
- Reset mid-write:
  - Assert rst_i during WAIT of a write of 0xAAAA...AAAA to 0x0020.
  - Outputs go to 0 immediately; no ACK.
  - A subsequent read of 0x0020 returns the old content.
- Cache-style writeback then refill:
  - Write 0x0030, drop valid one cycle after the ACK, then immediately read 0x0031.
  - Both serviced; read ACK at the expected LATENCY+2 offset after its sample edge.

Source files
------------

// File: rtl/qword_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qword_memory_responder_pkg
// Description : Qword bus geometry and responder state encoding, shared with
//               the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package qword_memory_responder_pkg;

    localparam int BUS_DATA_WIDTH_SHIFT = 4;
    localparam int BUS_DATA_WIDTH       = 128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/qword_ram.sv
`default_nettype none
// ============================================================================
// Module      : qword_ram
// Description : Single-port qword store, synchronous write, registered read.
//               Deliberately reset-free so it maps onto block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module qword_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Read register only updates on reads, so a write leaves it untouched.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                r_mem[addr_i] <= data_i;
            end else begin
                r_rd_data <= r_mem[addr_i];
            end
        end
    end

    assign data_o = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/qword_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : qword_memory_responder
// Description : Responder for the cache qword refill/writeback bus; services
//               one request at a time on a local store after LATENCY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module qword_memory_responder
    import qword_memory_responder_pkg::*;
#(
    parameter int BUS_ADDRESS_WIDTH = 20,
    parameter int MEM_DEPTH_LOG2    = 10,
    parameter int LATENCY           = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] bus_addr_i,
    input  logic                                          bus_valid_i,
    input  logic                                          bus_we_i,
    input  logic [BUS_DATA_WIDTH-1:0]                     bus_data_i,
    output logic [BUS_DATA_WIDTH-1:0]                     bus_data_o,
    output logic                                          bus_valid_o,
    output logic                                          bus_err_o
);

    localparam int          c_QADDR_W = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
    localparam logic [3:0]  c_LATENCY = 4'(LATENCY);

    resp_state_t                r_state;
    resp_state_t                w_next_state;
    logic [3:0]                 r_count;
    logic [MEM_DEPTH_LOG2-1:0]  r_addr;
    logic                       r_we;
    logic                       r_err;
    logic [BUS_DATA_WIDTH-1:0]  r_wdata;
    logic [BUS_DATA_WIDTH-1:0]  r_rd_hold;
    logic                       w_out_of_range;
    logic                       w_ram_en;
    logic                       w_ack;
    logic [BUS_DATA_WIDTH-1:0]  w_ram_q;
    logic [BUS_DATA_WIDTH-1:0]  w_data_out;

    // Range is decided from the raw address at capture; only in-range bits are kept.
    generate
        if (MEM_DEPTH_LOG2 < c_QADDR_W) begin : g_range_check
            assign w_out_of_range = |bus_addr_i[c_QADDR_W-1:MEM_DEPTH_LOG2];
        end else begin : g_range_full
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ram_en     = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_valid_i) begin
                    w_next_state = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_count <= 4'd1) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_ram_en     = ~r_err;
                w_next_state = ST_ACK;
            end
            ST_ACK: begin
                w_ack        = 1'b1;
                w_next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus_valid_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count   <= 4'd0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_wdata   <= '0;
            r_rd_hold <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus_valid_i) begin
                        r_count <= c_LATENCY;
                        r_addr  <= bus_addr_i[MEM_DEPTH_LOG2-1:0];
                        r_we    <= bus_we_i;
                        r_err   <= w_out_of_range;
                        r_wdata <= bus_data_i;
                    end
                end
                ST_WAIT: r_count <= r_count - 4'd1;
                ST_ACK: begin
                    if (!r_we) begin
                        r_rd_hold <= w_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

    qword_ram #(
        .ADDR_WIDTH (MEM_DEPTH_LOG2),
        .DATA_WIDTH (BUS_DATA_WIDTH)
    ) u_ram (
        .clk_i  (clk_i),
        .en_i   (w_ram_en),
        .we_i   (r_we),
        .addr_i (r_addr),
        .data_i (r_wdata),
        .data_o (w_ram_q)
    );

    // Read data appears straight from the RAM register during ACK, then is held.
    assign w_data_out  = (w_ack && !r_we) ? (r_err ? '0 : w_ram_q) : r_rd_hold;
    assign bus_data_o  = w_data_out;
    assign bus_valid_o = w_ack;
    assign bus_err_o   = w_ack & r_err;

endmodule
`default_nettype wire

// File: tb/tb_qword_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qword_memory_responder
// Description : Scoreboard bench for qword_memory_responder, LATENCY=2 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qword_memory_responder;

    typedef struct {
        int           lat;
        logic         err;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        int           sel;
        logic         w;
        logic [15:0]  a;
        logic [127:0] d;
        int           hold;
    } req_t;

    logic         clk, rst;
    logic [15:0]  addr;
    logic         we;
    logic [127:0] wdata;
    logic         va, vb;
    logic [127:0] da, db;
    logic         ova, ovb, ea, eb;

    int           checks;
    int           failures;
    exp_t         sb_q[$];
    logic [127:0] mdl[int];
    logic [127:0] last_rd[2];

    qword_memory_responder #(.BUS_ADDRESS_WIDTH(20), .MEM_DEPTH_LOG2(10), .LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .rst_i(rst), .bus_addr_i(addr), .bus_valid_i(va), .bus_we_i(we),
        .bus_data_i(wdata), .bus_data_o(da), .bus_valid_o(ova), .bus_err_o(ea)
    );

    qword_memory_responder #(.BUS_ADDRESS_WIDTH(20), .MEM_DEPTH_LOG2(10), .LATENCY(0)) u_dut_l0 (
        .clk_i(clk), .rst_i(rst), .bus_addr_i(addr), .bus_valid_i(vb), .bus_we_i(we),
        .bus_data_i(wdata), .bus_data_o(db), .bus_valid_o(ovb), .bus_err_o(eb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, pushes its expectation, and reports what the DUT did.
    task automatic run_req(input req_t r, output logic got, output int cyc,
                           output logic err, output logic [127:0] data, output int extra);
        exp_t e;
        int   key;
        key   = r.sel * 65536 + int'(r.a);
        e.lat = ((r.sel == 0) ? 2 : 0) + 2;
        e.err = (r.a[15:10] != 6'd0);
        if (r.w) begin
            e.data = last_rd[r.sel];
            if (!e.err) mdl[key] = r.d;
        end else begin
            e.data = e.err ? 128'd0 : mdl[key];
            last_rd[r.sel] = e.data;
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
        addr = r.a; we = r.w; wdata = r.d;
        if (r.sel == 0) va = 1'b1; else vb = 1'b1;
        got = 1'b0; cyc = 0; err = 1'b0; data = '0; extra = 0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if ((r.sel == 0) ? ova : ovb) begin
                got  = 1'b1;
                err  = (r.sel == 0) ? ea : eb;
                data = (r.sel == 0) ? da : db;
            end
        end
        for (int i = 0; i < r.hold; i++) begin
            @(posedge clk); #1;
            if ((r.sel == 0) ? (ova | ea) : (ovb | eb)) extra++;
        end
        va = 1'b0; vb = 1'b0;
        addr = 16'hFFFF; wdata = {128{1'b1}}; we = ~r.w;
    endtask

    task automatic run_table(input string name, input req_t reqs[$]);
        logic got, err; int cyc, extra; logic [127:0] data; exp_t e;
        foreach (reqs[k]) begin
            run_req(reqs[k], got, cyc, err, data, extra);
            e = sb_q.pop_front();
            checks++;
            if (!got || cyc != e.lat || err !== e.err || data !== e.data || extra != 0) begin
                failures++;
                $display("FAIL %s[%0d]: got_ack=%0b cyc=%0d err=%0b data=%h extra=%0d ; required cyc=%0d err=%0b data=%h extra=0",
                         name, k, got, cyc, err, data, extra, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; va = 1'b0; vb = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ova !== 1'b0 || ea !== 1'b0 || da !== 128'd0) begin
            failures++;
            $display("FAIL reset_l2: valid=%0b err=%0b data=%h ; required 0 0 0", ova, ea, da);
        end
        checks++;
        if (ovb !== 1'b0 || eb !== 1'b0 || db !== 128'd0) begin
            failures++;
            $display("FAIL reset_l0: valid=%0b err=%0b data=%h ; required 0 0 0", ovb, eb, db);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        req_t q[$];
        q.push_back('{0, 1'b1, 16'h0005, 128'h0123456789ABCDEF_FEDCBA9876543210, 1});
        q.push_back('{0, 1'b0, 16'h0005, 128'h0, 1});
        run_table("write_read", q);
    endtask

    task automatic test_latency0();
        req_t q[$];
        q.push_back('{1, 1'b1, 16'h03FF, 128'hC0DE_0000_1111_2222_3333_4444_5555_03FF, 1});
        q.push_back('{1, 1'b1, 16'h0000, 128'h0BAD_F00D_0000_0000_0000_0000_0000_0000, 1});
        q.push_back('{1, 1'b0, 16'h03FF, 128'h0, 1});
        q.push_back('{1, 1'b0, 16'h0000, 128'h0, 1});
        run_table("latency0", q);
    endtask

    task automatic test_held_request();
        req_t q[$];
        q.push_back('{0, 1'b1, 16'h0010, 128'h1010_2020_3030_4040_5050_6060_7070_8080, 1});
        q.push_back('{0, 1'b0, 16'h0010, 128'h0, 10});
        q.push_back('{0, 1'b0, 16'h0005, 128'h0, 1});
        run_table("held_request", q);
    endtask

    task automatic test_out_of_range();
        req_t q[$];
        q.push_back('{0, 1'b1, 16'h0000, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, 1});
        q.push_back('{0, 1'b1, 16'h0400, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1});
        q.push_back('{0, 1'b0, 16'h0000, 128'h0, 1});
        q.push_back('{0, 1'b0, 16'h0400, 128'h0, 1});
        q.push_back('{1, 1'b0, 16'h8400, 128'h0, 1});
        run_table("out_of_range", q);
    endtask

    task automatic test_reset_mid_write();
        req_t q[$];
        int   acks;
        q.push_back('{0, 1'b1, 16'h0020, 128'h2020_0000_FFFF_0000_2020_0000_FFFF_0000, 1});
        q.push_back('{0, 1'b0, 16'h0020, 128'h0, 1});
        run_table("pre_abort", q);
        @(posedge clk); #1;
        addr = 16'h0020; we = 1'b1; wdata = {64{2'b10}}; va = 1'b1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ova !== 1'b0 || ea !== 1'b0 || da !== 128'd0) begin
            failures++;
            $display("FAIL abort_outputs: valid=%0b err=%0b data=%h ; required 0 0 0", ova, ea, da);
        end
        va = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ova) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL abort_no_ack: acks=%0d ; required 0", acks);
        end
        q.delete();
        q.push_back('{0, 1'b0, 16'h0020, 128'h0, 1});
        run_table("post_abort", q);
    endtask

    task automatic test_back_to_back();
        req_t q[$];
        q.push_back('{0, 1'b1, 16'h0031, 128'h3131_3131_0000_0000_3131_3131_0000_0031, 1});
        q.push_back('{0, 1'b1, 16'h0030, 128'h3030_3030_FFFF_FFFF_3030_3030_FFFF_0030, 1});
        q.push_back('{0, 1'b0, 16'h0031, 128'h0, 1});
        q.push_back('{0, 1'b0, 16'h0030, 128'h0, 1});
        q.push_back('{1, 1'b1, 16'h0031, 128'hABCD_0000_0000_0000_0000_0000_0000_1031, 1});
        q.push_back('{1, 1'b0, 16'h0031, 128'h0, 1});
        run_table("back_to_back", q);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_latency0();
        test_held_request();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
